cut_position_scheduler: RTL and testbench
=========================================

Name: cut_position_scheduler

Overview:
Sequencer for the line-rotation scrambler. It tracks BT.656 timing (H/V/F from the sync parser) and produces a per-line cut position for the line rotator from a keyed Galois LFSR. Key loading uses a valid/ready handshake and takes effect only at a frame boundary, so scrambler and descrambler stay in lockstep. It sits between the key source and the line rotator's raw_cut_position input.

Parameters:
LFSR_WIDTH, 32, width of the keyed LFSR state and key.
LFSR_TAPS, 32'h80200003, Galois feedback mask (x^32+x^22+x^2+x+1).
CUT_WIDTH, 8, width of the cut_position output.
LINE_CNT_WIDTH, 10, width of the active-line counter (525-line frames).

Ports:
clk  input  1  pixel/byte clock
reset_n  input  1  asynchronous, active-low reset
enable  input  1  1 = scramble; 0 = force cut_position to 0 (pass-through)
H  input  1  horizontal blanking flag from sync parser
V  input  1  vertical blanking flag from sync parser
F  input  1  field flag from sync parser
key  input  LFSR_WIDTH  seed value
key_valid  input  1  key offered
key_ready  output  1  scheduler can accept a key
cut_position  output  CUT_WIDTH  cut position for the current line
cut_valid  output  1  1 while RUNNING and cut_position is LFSR-derived
line_count  output  LINE_CNT_WIDTH  active lines since frame start
frame_start  output  1  one-cycle pulse at each detected frame start

Behaviour:
- Reset: state=IDLE, lfsr=0, pending key=0, key_pending=0, cut_position=0, cut_valid=0, line_count=0, frame_start=0, key_ready=1; h_q/f_q edge registers cleared.
- Events (combinational from registered previous values): h_rise = H & ~h_q (EAV, line boundary); frame_evt = ~F & f_q (field 2 -> field 1).
- Handshake: accept when key_valid & key_ready. key_ready = ~key_pending. Accepted key is latched as pending; key 0 is stored as 1 (LFSR lock-up guard).
- States:
  IDLE: cut_position=0, cut_valid=0. Accept key -> ARMED.
  ARMED: wait for frame_evt; then lfsr<=pending key, key_pending<=0 -> RUNNING.
  RUNNING: on h_rise with V=0: lfsr<=step(lfsr), cut_position<=step(lfsr)[CUT_WIDTH-1:0], line_count+1 (saturating at all-ones). On h_rise with V=1: hold cut_position and lfsr. On frame_evt with key_pending: reload lfsr from pending key, clear pending; otherwise lfsr continues.
- step(x) = (x>>1) ^ (x[0] ? LFSR_TAPS : 0).
- Latency: cut_position changes on the clock edge where h_rise is true, i.e. it is visible one cycle after the first sampled H=1 and is stable for the whole following line.
- frame_evt: line_count<=0, frame_start pulses for one cycle (in all states).
- Simultaneous h_rise and frame_evt: reload first, then no step that cycle; line_count=0.
- Key accept in the same cycle as frame_evt: key becomes pending and is applied at the next frame_evt.
- enable=0: cut_position forced 0 (registered, next cycle), cut_valid=0; LFSR and counters keep advancing so sync is preserved.
- reset_n low mid-line: immediate return to reset values; a new key is required.

Optional Feature:
FIELD_RESEED_EN: when defined, every frame_evt in RUNNING reloads lfsr from the last applied key (or the pending key, if present), so every frame repeats the same cut sequence and the descrambler recovers after dropouts. When not defined, the LFSR free-runs across frames and reloads only on a pending key.

Decomposition:
- Shared package line_rotation_pkg holds LFSR_TAPS default, CUT_WIDTH/LFSR_WIDTH constants, and the state enum {IDLE, ARMED, RUNNING}.
- Sub-module lfsr_galois: load/step/value, parameterised by width and taps. The scheduler holds the FSM, edge detect, handshake and counters.

Test Plan:
- Reset then key=32'h00000001 offered -> key_ready=1, accepted in 1 cycle; ARMED until F 1->0; then the first three active-line h_rise give cut_position 8'h03, 8'h02, 8'h01 with cut_valid=1.
- key=0 -> treated as 1; same sequence 03, 02, 01.
- h_rise during V=1 (lines 1-19) -> cut_position held, line_count unchanged; first active line steps once.
- Second key offered while RUNNING -> key_ready drops to 0 until the next frame_evt; the new sequence starts there; line_count resets to 0 with a frame_start pulse.
- enable=0 for 5 lines then 1 -> cut_position=0 during those lines; after re-enable, the value equals the LFSR value 6 steps past the last enabled line (no desync).
- Assert reset_n low mid-RUNNING -> all outputs at reset values the same cycle; with FIELD_RESEED_EN, two consecutive frames produce identical cut sequences.

Source files
------------

// File: rtl/cut_position_scheduler_pkg.sv
// Shared constants, state type and LFSR step helper for the line-rotation
// cut-position scheduler.
//   LFSR_WIDTH     : width of the keyed LFSR state and key
//   LFSR_TAPS      : Galois feedback mask (x^32+x^22+x^2+x+1)
//   CUT_WIDTH      : width of the cut position handed to the line rotator
//   LINE_CNT_WIDTH : width of the active-line counter (525-line frames)
package cut_position_scheduler_pkg;

    localparam int LFSR_WIDTH     = 32;
    localparam int CUT_WIDTH      = 8;
    localparam int LINE_CNT_WIDTH = 10;

    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RUNNING = 2'd2
    } state_e;

    // One Galois shift: the bit falling out of the LSB folds the taps back in.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] x);
        return (x >> 1) ^ (x[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/cut_position_scheduler_if.sv
// Signal bundle between the sync parser / key source and the scheduler.
//   master : drives enable, H/V/F timing flags, key and key_valid
//   slave  : returns key_ready, cut_position, cut_valid, line_count, frame_start
interface cut_position_scheduler_if;
    import cut_position_scheduler_pkg::*;

    logic                      enable;
    logic                      H;
    logic                      V;
    logic                      F;
    logic [LFSR_WIDTH-1:0]     key;
    logic                      key_valid;
    logic                      key_ready;
    logic [CUT_WIDTH-1:0]      cut_position;
    logic                      cut_valid;
    logic [LINE_CNT_WIDTH-1:0] line_count;
    logic                      frame_start;

    modport master (
        output enable, H, V, F, key, key_valid,
        input  key_ready, cut_position, cut_valid, line_count, frame_start
    );

    modport slave (
        input  enable, H, V, F, key, key_valid,
        output key_ready, cut_position, cut_valid, line_count, frame_start
    );

endinterface

// File: rtl/cut_position_scheduler_lfsr.sv
// Keyed Galois LFSR used as the cut-position source.
//   clk, reset_n : clock, asynchronous active-low reset (state clears to 0)
//   load_i       : replace the state with load_val_i (wins over step_i)
//   load_val_i   : seed value
//   step_i       : advance one Galois step
//   value_o      : current LFSR state
module lfsr_galois
    import cut_position_scheduler_pkg::*;
#(
    parameter int               WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (step_i) begin
            value_d = (value_q >> 1) ^ (value_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/cut_position_scheduler.sv
// Per-line cut-position sequencer for the line-rotation scrambler. Tracks
// BT.656 H/V/F, accepts a seed over a valid/ready handshake and applies it
// only at a frame boundary so scrambler and descrambler stay in lockstep.
//   clk, reset_n : pixel clock, asynchronous active-low reset
//   sif          : slave side of cut_position_scheduler_if
// Build option FIELD_RESEED_EN: every frame start while running reloads the
// LFSR from the last applied key (or the pending one), so each frame repeats
// the same cut sequence. Without it the LFSR free-runs across frames.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no key yet, cut_position held at 0
// ARMED   | key latched, waiting for the next frame start to load it
// RUNNING | LFSR steps once per active line, cut_position is live
module cut_position_scheduler
    import cut_position_scheduler_pkg::*;
(
    input logic                     clk,
    input logic                     reset_n,
    cut_position_scheduler_if.slave sif
);

    state_e                    state_q, state_d;
    logic                      h_q, f_q;
    logic [LFSR_WIDTH-1:0]     pend_key_q, pend_key_d;
    logic                      key_pending_q, key_pending_d;
    logic [CUT_WIDTH-1:0]      cut_q, cut_d;
    logic                      cut_valid_q, cut_valid_d;
    logic [LINE_CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
    logic                      frame_start_q;
`ifdef FIELD_RESEED_EN
    logic [LFSR_WIDTH-1:0]     last_key_q, last_key_d;
`endif

    logic                      lfsr_load, lfsr_step_en;
    logic [LFSR_WIDTH-1:0]     lfsr_load_val, lfsr_value, lfsr_next;
    logic                      h_rise, frame_evt, key_accept;

    // EAV marks the line boundary; field 2 -> field 1 marks the frame start.
    assign h_rise     = sif.H & ~h_q;
    assign frame_evt  = ~sif.F & f_q;
    assign key_accept = sif.key_valid & ~key_pending_q;
    assign lfsr_next  = lfsr_step(lfsr_value);

    lfsr_galois #(
        .WIDTH (LFSR_WIDTH),
        .TAPS  (LFSR_TAPS)
    ) u_lfsr (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (lfsr_load),
        .load_val_i (lfsr_load_val),
        .step_i     (lfsr_step_en),
        .value_o    (lfsr_value)
    );

    always_comb begin
        state_d       = state_q;
        pend_key_d    = pend_key_q;
        key_pending_d = key_pending_q;
        cut_d         = cut_q;
        line_cnt_d    = line_cnt_q;
        lfsr_load     = 1'b0;
        lfsr_step_en  = 1'b0;
        lfsr_load_val = pend_key_q;
`ifdef FIELD_RESEED_EN
        last_key_d    = last_key_q;
`endif

        unique case (state_q)
            IDLE: begin
                cut_d = '0;
                if (key_accept) state_d = ARMED;
            end
            ARMED: begin
                cut_d = '0;
                if (frame_evt) begin
                    lfsr_load     = 1'b1;
                    key_pending_d = 1'b0;
                    state_d       = RUNNING;
`ifdef FIELD_RESEED_EN
                    last_key_d    = pend_key_q;
`endif
                end
            end
            RUNNING: begin
                // A frame start never steps, even when it coincides with EAV.
                if (frame_evt) begin
                    if (key_pending_q) begin
                        lfsr_load     = 1'b1;
                        key_pending_d = 1'b0;
`ifdef FIELD_RESEED_EN
                        last_key_d    = pend_key_q;
`endif
                    end
`ifdef FIELD_RESEED_EN
                    else begin
                        lfsr_load     = 1'b1;
                        lfsr_load_val = last_key_q;
                    end
`endif
                end else if (h_rise && !sif.V) begin
                    lfsr_step_en = 1'b1;
                    cut_d        = lfsr_next[CUT_WIDTH-1:0];
                    if (line_cnt_q != '1) line_cnt_d = line_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Only reachable with nothing pending, so it never races the reload above.
        if (key_accept) begin
            pend_key_d    = (sif.key == '0) ? LFSR_WIDTH'(1) : sif.key;
            key_pending_d = 1'b1;
        end

        if (frame_evt) line_cnt_d = '0;

        // Pass-through forces the output only; LFSR and counters keep running.
        if (!sif.enable) cut_d = '0;
        cut_valid_d = sif.enable && (state_d == RUNNING);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            h_q           <= 1'b0;
            f_q           <= 1'b0;
            pend_key_q    <= '0;
            key_pending_q <= 1'b0;
            cut_q         <= '0;
            cut_valid_q   <= 1'b0;
            line_cnt_q    <= '0;
            frame_start_q <= 1'b0;
`ifdef FIELD_RESEED_EN
            last_key_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            h_q           <= sif.H;
            f_q           <= sif.F;
            pend_key_q    <= pend_key_d;
            key_pending_q <= key_pending_d;
            cut_q         <= cut_d;
            cut_valid_q   <= cut_valid_d;
            line_cnt_q    <= line_cnt_d;
            frame_start_q <= frame_evt;
`ifdef FIELD_RESEED_EN
            last_key_q    <= last_key_d;
`endif
        end
    end

    assign sif.key_ready    = ~key_pending_q;
    assign sif.cut_position = cut_q;
    assign sif.cut_valid    = cut_valid_q;
    assign sif.line_count   = line_cnt_q;
    assign sif.frame_start  = frame_start_q;

endmodule

// File: tb/tb_cut_position_scheduler.sv
// Bench for cut_position_scheduler. Expected values come from a line/frame
// level model: each active line is one LFSR step, each frame start resets the
// line count and applies a pending key.
module tb_cut_position_scheduler;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    cut_position_scheduler_if bus();

    cut_position_scheduler dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sif     (bus)
    );

    localparam int LC_MAX = 1023;

    int checks = 0;
    int errors = 0;

    bit        m_run, m_armed, m_pend, m_en;
    bit [31:0] m_lfsr, m_pkey, m_last;
    bit [7:0]  m_cut;
    int        m_lc;

    function automatic bit [31:0] mstep(input bit [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string where);
        check({where, " cut_position"}, 32'(bus.cut_position), 32'(m_cut));
        check({where, " cut_valid"},    32'(bus.cut_valid),    32'(m_run & m_en));
        check({where, " key_ready"},    32'(bus.key_ready),    32'(!m_pend));
        check({where, " line_count"},   32'(bus.line_count),   32'(m_lc));
    endtask

    task automatic model_reset();
        m_run = 0; m_armed = 0; m_pend = 0;
        m_lfsr = 0; m_pkey = 0; m_last = 0;
        m_cut = 0; m_lc = 0;
    endtask

    // One video line: EAV (H high two cycles) then two cycles of active video.
    task automatic hline(input bit v);
        bus.V = v;
        bus.H = 1'b1;
        tick();
        if (m_run && !v) begin
            m_lfsr = mstep(m_lfsr);
            m_cut  = m_en ? m_lfsr[7:0] : 8'h00;
            if (m_lc < LC_MAX) m_lc++;
        end
        check_outputs("line");
        tick();
        bus.H = 1'b0;
        tick();
        tick();
    endtask

    task automatic accept_in_model(input bit [31:0] k);
        if (!m_pend) begin
            m_pend = 1;
            m_pkey = (k == 0) ? 32'd1 : k;
            if (!m_run && !m_armed) m_armed = 1;
        end
    endtask

    task automatic offer_key(input bit [31:0] k);
        bus.key       = k;
        bus.key_valid = 1'b1;
        check("key_ready before offer", 32'(bus.key_ready), 32'(!m_pend));
        tick();
        bus.key_valid = 1'b0;
        accept_in_model(k);
        check_outputs("key");
    endtask

    // Field 2 for one cycle, then the F fall that starts a frame. Optionally
    // offers a key in the same cycle as the frame start.
    task automatic frame(input bit with_key, input bit [31:0] k);
        bus.F = 1'b1;
        tick();
        bus.F = 1'b0;
        if (with_key) begin
            bus.key       = k;
            bus.key_valid = 1'b1;
        end
        tick();
        bus.key_valid = 1'b0;
        m_lc = 0;
        if (m_armed) begin
            m_lfsr = m_pkey; m_last = m_pkey; m_pend = 0; m_armed = 0; m_run = 1;
        end else if (m_run) begin
            if (m_pend) begin
                m_lfsr = m_pkey; m_last = m_pkey; m_pend = 0;
            end
`ifdef FIELD_RESEED_EN
            else begin
                m_lfsr = m_last;
            end
`endif
        end
        if (with_key) accept_in_model(k);
        check("frame_start pulse", 32'(bus.frame_start), 32'd1);
        check_outputs("frame");
        tick();
        check("frame_start one cycle", 32'(bus.frame_start), 32'd0);
    endtask

    task automatic set_enable(input bit e);
        bus.enable = e;
        tick();
        m_en = e;
        if (!e) m_cut = 8'h00;
        check_outputs("enable");
    endtask

    // Reset lands between clock edges; outputs must clear without a clock.
    task automatic async_reset();
        reset_n = 1'b0;
        #2;
        check("reset cut_position", 32'(bus.cut_position), 32'd0);
        check("reset cut_valid",    32'(bus.cut_valid),    32'd0);
        check("reset line_count",   32'(bus.line_count),   32'd0);
        check("reset key_ready",    32'(bus.key_ready),    32'd1);
        check("reset frame_start",  32'(bus.frame_start),  32'd0);
        model_reset();
        bus.H = 1'b0; bus.V = 1'b0; bus.F = 1'b0; bus.key_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check_outputs("after reset");
    endtask

    initial begin
        logic [7:0]  seq [3];
        logic [23:0] seq_a, seq_b;
        logic [7:0]  held;
        bit   [31:0] k2, x;

        reset_n       = 1'b0;
        bus.enable    = 1'b1;
        bus.H         = 1'b0;
        bus.V         = 1'b0;
        bus.F         = 1'b0;
        bus.key       = '0;
        bus.key_valid = 1'b0;
        m_en          = 1;
        model_reset();
        tick();
        tick();
        check_outputs("power-on reset");
        check("power-on frame_start", 32'(bus.frame_start), 32'd0);
        reset_n = 1'b1;
        tick();

        // Key 1: armed until frame start, then 03, 02, 01.
        offer_key(32'h0000_0001);
        hline(0);
        hline(0);
        check("armed cut_valid", 32'(bus.cut_valid), 32'd0);
        frame(0, 0);
        for (int i = 0; i < 3; i++) begin
            hline(0);
            seq[i] = bus.cut_position;
        end
        check("key1 line1", 32'(seq[0]), 32'h03);
        check("key1 line2", 32'(seq[1]), 32'h02);
        check("key1 line3", 32'(seq[2]), 32'h01);

        // Key 0 behaves as key 1.
        async_reset();
        offer_key(32'h0000_0000);
        frame(0, 0);
        for (int i = 0; i < 3; i++) begin
            hline(0);
            seq[i] = bus.cut_position;
        end
        check("key0 line1", 32'(seq[0]), 32'h03);
        check("key0 line2", 32'(seq[1]), 32'h02);
        check("key0 line3", 32'(seq[2]), 32'h01);

        // Vertical blanking lines hold cut and count.
        frame(0, 0);
        hline(0);
        held = bus.cut_position;
        for (int i = 0; i < 19; i++) hline(1);
        check("vblank cut held",   32'(bus.cut_position), 32'(held));
        check("vblank count held", 32'(bus.line_count),   32'd1);
        hline(0);

        // Second key while running: pending until the next frame start.
        k2 = 32'hCAFE_1234;
        offer_key(k2);
        hline(0);
        check("key_ready low while pending", 32'(bus.key_ready), 32'd0);
        frame(0, 0);
        check("key_ready after apply", 32'(bus.key_ready), 32'd1);
        hline(0);
        x = mstep(k2);
        check("new key first cut", 32'(bus.cut_position), 32'(x[7:0]));

        // Pass-through for five lines, then resume without desync.
        x = m_lfsr;
        set_enable(0);
        for (int i = 0; i < 5; i++) hline(0);
        set_enable(1);
        hline(0);
        for (int i = 0; i < 6; i++) x = mstep(x);
        check("resume after pass-through", 32'(bus.cut_position), 32'(x[7:0]));

        // Key accepted in the same cycle as a frame start waits a full frame.
        frame(1, 32'h0BAD_F00D);
        hline(0);
        frame(0, 0);
        hline(0);

        // Mid-running reset, then same-key frames: repeat with reseed, else differ.
        bus.H = 1'b1;
        async_reset();
        offer_key(32'h1234_5678);
        frame(0, 0);
        for (int i = 0; i < 3; i++) begin
            hline(0);
            seq[i] = bus.cut_position;
        end
        seq_a = {seq[0], seq[1], seq[2]};
        frame(0, 0);
        for (int i = 0; i < 3; i++) begin
            hline(0);
            seq[i] = bus.cut_position;
        end
        seq_b = {seq[0], seq[1], seq[2]};
`ifdef FIELD_RESEED_EN
        check("reseed frames identical", 32'(seq_b), 32'(seq_a));
`else
        check("free-run frames differ", 32'(seq_b != seq_a), 32'd1);
`endif

        // Randomized frames: keys, key-on-frame, enable toggles, blanking depth.
        for (int fr = 0; fr < 12; fr++) begin
            int nv;
            int na;
            nv = $urandom_range(0, 4);
            na = $urandom_range(1, 8);
            for (int l = 0; l < nv; l++) hline(1);
            for (int l = 0; l < na; l++) begin
                hline(0);
                if ($urandom_range(0, 5) == 0) offer_key($urandom);
                if ($urandom_range(0, 6) == 0) set_enable(!m_en);
            end
            frame($urandom_range(0, 4) == 0, $urandom);
        end
        if (!m_en) set_enable(1);

        // Line counter saturation, then cleared by the frame start.
        for (int l = 0; l < LC_MAX + 7; l++) hline(0);
        check("line_count saturates", 32'(bus.line_count), 32'd1023);
        frame(0, 0);
        check("line_count cleared", 32'(bus.line_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
